// File: rtl/dmem_responder.sv
// dmem_responder
//
// Memory-side responder for the core's load/store port. Accepts one request
// at a time, waits a programmable number of cycles, performs the access on
// the last wait edge and returns a one-cycle response. Stalls the pipeline
// while an access is outstanding.
//
// Parameters:
//   DEPTH_BYTES  byte-addressed storage size (power of two)
//   LATENCY      wait cycles between acceptance and response (1..15)
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous active-low reset
//   req_valid     request present, held until accepted
//   req_write     1 = store, 0 = load
//   req_addr      byte address (bits above log2(DEPTH_BYTES) ignored)
//   req_wdata     store data, low bytes used per req_size
//   req_size      0 byte, 1 half, 2 word, 3 double
//   req_unsigned  load zero-extends when 1, sign-extends when 0
//   req_ready     responder can accept a request this cycle
//   resp_valid    one-cycle response pulse
//   resp_rdata    load result (0 for stores), held outside RESP
//   busy          stall request to the pipeline
//   misaligned    (DMEM_MISALIGN_TRAP_EN only) high with resp_valid when the
//                 access was not size-aligned; store suppressed, load returns 0
//
// Optional feature macro: DMEM_MISALIGN_TRAP_EN
//
// State  | meaning
// IDLE   | ready for a request; captures it when req_valid
// WAIT   | counting down wait cycles; access happens on the edge at count 0
// RESP   | resp_valid pulse; incoming requests ignored

module dmem_responder #(
    parameter int DEPTH_BYTES = 512,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        busy
`ifdef DMEM_MISALIGN_TRAP_EN
    ,
    output logic        misaligned
`endif
);

    localparam int AW = $clog2(DEPTH_BYTES);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic [AW-1:0] addr_q;
    logic [63:0]   wdata_q;
    logic [1:0]    size_q;
    logic          write_q;
    logic          unsigned_q;
    logic          mis_q;
    logic          fire;
    logic [3:0]    nbytes;
    logic [63:0]   raw;
    logic [63:0]   load_data;
    logic [7:0]    mem [DEPTH_BYTES];
    logic          unused_addr;

    assign unused_addr = ^req_addr[63:AW];

    assign req_ready = (state == IDLE);
    assign busy      = (state == WAIT) || ((state == IDLE) && req_valid);
    assign fire      = (state == WAIT) && (cnt == 4'd0);
    assign nbytes    = 4'd1 << size_q;

    // Byte i comes from (addr + i) truncated to AW bits, so accesses wrap
    // byte-wise past the top of storage.
    always_comb begin
        raw = '0;
        for (int i = 0; i < 8; i++) begin
            raw[i*8 +: 8] = mem[addr_q + AW'(i)];
        end
        case (size_q)
            2'd0:    load_data = unsigned_q ? {56'd0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
            2'd1:    load_data = unsigned_q ? {48'd0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
            2'd2:    load_data = unsigned_q ? {32'd0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
            default: load_data = raw;
        endcase
    end

    // Storage is not reset. A reset during WAIT forces IDLE, so fire never
    // rises and a pending store is dropped.
    always_ff @(posedge clk) begin
        if (fire && write_q && !mis_q) begin
            for (int i = 0; i < 8; i++) begin
                if (4'(i) < nbytes) begin
                    mem[addr_q + AW'(i)] <= wdata_q[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            resp_valid <= 1'b0;
            resp_rdata <= 64'd0;
            addr_q     <= '0;
            wdata_q    <= 64'd0;
            size_q     <= 2'd0;
            write_q    <= 1'b0;
            unsigned_q <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q     <= req_addr[AW-1:0];
                        wdata_q    <= req_wdata;
                        size_q     <= req_size;
                        write_q    <= req_write;
                        unsigned_q <= req_unsigned;
                        cnt        <= 4'(LATENCY - 1);
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= (write_q || mis_q) ? 64'd0 : load_data;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    function automatic logic is_misaligned(input logic [2:0] a, input logic [1:0] sz);
        case (sz)
            2'd0:    return 1'b0;
            2'd1:    return a[0];
            2'd2:    return |a[1:0];
            default: return |a;
        endcase
    endfunction

    logic mis_r;
    assign mis_q = mis_r;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mis_r      <= 1'b0;
            misaligned <= 1'b0;
        end else begin
            if ((state == IDLE) && req_valid) begin
                mis_r <= is_misaligned(req_addr[2:0], req_size);
            end
            misaligned <= fire && mis_r;
        end
    end
`else
    assign mis_q = 1'b0;
`endif

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the core's load/store port.
- Accepts one request at a time from the EX/MEM stage: address, write data, write/read flag and access size.
- Services the request after a programmable number of wait states, then returns a one-cycle response.
- Drives a stall signal to the pipeline while an access is outstanding. Replaces the single-cycle data memory when multi-cycle memory timing is modelled.

Parameters:
- DEPTH_BYTES, 512, size of byte-addressed storage; power of two.
- LATENCY, 2, wait cycles between acceptance and response; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- req_valid  input  1  request present; held by the pipeline until accepted.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  64  byte address.
- req_wdata  input  64  store data; low bytes used per req_size.
- req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = double.
- req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
- req_ready  output  1  responder can accept a request this cycle.
- resp_valid  output  1  one-cycle response/acknowledge pulse.
- resp_rdata  output  64  load result; 0 for stores.
- busy  output  1  stall request to the pipeline.

Behaviour:
- FSM states: IDLE, WAIT, RESP. State register and all outputs are reset asynchronously when reset = 0.
- Reset values: state = IDLE, resp_valid = 0, resp_rdata = 0, wait counter = 0. Storage contents are not reset.
- IDLE: req_ready = 1.
  - If req_valid = 1, capture addr, wdata, size, write and unsigned flags.
  - Load the counter with LATENCY-1 and go to WAIT.
- WAIT: req_ready = 0.
  - Counter decrements each cycle.
  - When the counter is 0, perform the access on that edge and go to RESP.
- Access semantics:
  - Little-endian.
  - Byte i of the access is located at (addr + i) mod DEPTH_BYTES, so accesses wrap byte-wise past the top of storage.
  - Store writes 1/2/4/8 bytes.
  - Load assembles the same byte count and extends to 64 bits per req_unsigned.
  - Double loads ignore req_unsigned.
- RESP:
  - resp_valid = 1 for exactly one cycle; resp_rdata holds the load result, or 0 for stores.
  - req_ready = 0, and any req_valid in this cycle is ignored.
  - Next state is IDLE.
- resp_rdata holds its last value outside RESP.
- Latency: request accepted on edge N; resp_valid is high in cycle N+LATENCY+1.
- busy (combinational) = (state == WAIT) or (state == IDLE and req_valid). busy = 0 during RESP, so the pipeline advances and captures resp_rdata in that cycle.
- Writes commit only on the final WAIT edge. Reset asserted during WAIT drops the pending store (no bytes modified) and any pending load.
- Back-to-back requests: minimum spacing is LATENCY+2 cycles (accept, WAIT cycles, RESP).
- Upper address bits above log2(DEPTH_BYTES) are ignored.

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- When defined:
  - Adds output port misaligned (1 bit, reset 0).
  - A request is misaligned when req_addr is not a multiple of its access size.
  - A misaligned request is still accepted and timed normally.
  - The store is suppressed; a load returns 0.
  - misaligned is high during the RESP cycle together with resp_valid.
- When undefined: misaligned accesses execute normally with byte-wise wrap, and the port does not exist.

Test Plan:
- Double store, then double load:
  - Store req_addr=0x10, size=3, wdata=0x1122334455667788.
  - Load the same address and size.
  - Expect resp_rdata=0x1122334455667788, with resp_valid exactly LATENCY+1 cycles after acceptance.
- Signed byte load: store byte 0x80 at 0x21. Load size=0 with req_unsigned=0 → 0xFFFFFFFFFFFFFF80; with req_unsigned=1 → 0x0000000000000080.
- Top-of-storage wrap:
  - Store half 0xBEEF at addr DEPTH_BYTES-1.
  - Byte load at DEPTH_BYTES-1 → 0xEF; byte load at 0 → 0xBE.
  - With DMEM_MISALIGN_TRAP_EN defined: misaligned=1 and neither byte changes.
- Handshake timing:
  - Hold req_valid high across two back-to-back requests.
  - Expect req_ready and busy to follow the FSM rules above.
  - Expect the second request to be accepted only in the IDLE cycle after RESP.
- Reset mid-access:
  - Prefill address 0x40 with 0x0.
  - Issue store wdata=0xFFFFFFFFFFFFFFFF to 0x40, size=3, and pull reset low during WAIT.
  - Expect resp_valid=0 and state IDLE immediately.
  - A subsequent load of 0x40 returns the prefilled 0x0.
- LATENCY=1 build: load accepted on edge N → resp_valid high in cycle N+2, busy high only in cycle N and the WAIT cycle.
